if_id_buffer: RTL and testbench

- Fetch-to-decode boundary of the pipelined MIPS core.
- Sits directly downstream of pc_counter and instruction memory. Captures each fetched instruction with its PC into a small FIFO and presents the head entry to the decode stage.
- Produces the advance/hold signal that drives the PC register's stall input.
- Decouples fetch from decode stalls and discards wrong-path instructions on a flush.

---
 rtl/if_id_buffer.sv | 134 +++++++++++++
 tb/tb_if_id_buffer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode boundary of the pipelined MIPS core.
// Buffers fetched {PC, instruction} pairs in a small FIFO, presents the head
// entry to decode and tells the PC register when it may advance (readyF).
// Optional build macro IF_ID_PERF_CNT_EN adds stall/bubble cycle counters.
module if_id_buffer #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    PCF,
    input  logic [31:0]                    InstrF,
    input  logic                           validF,
    output logic                           readyF,
    input  logic                           stallD,
    input  logic                           flushD,
    output logic [31:0]                    InstrD,
    output logic [31:0]                    PCD,
    output logic [31:0]                    PCPlus4D,
    output logic                           validD,
    output logic [$clog2(DEPTH+1)-1:0]     count
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]                    stall_cycles,
    output logic [31:0]                    bubble_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage is never reset: occupancy alone decides what is valid.
    logic [31:0]      instr_mem_q [DEPTH];
    logic [31:0]      pc_mem_q    [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             enq;
    logic             deq;

    // Handshake: readyF depends only on registered occupancy, never on stallD/flushD.
    always_comb begin
        readyF = (count_q < FULL_CNT);
        validD = (count_q != '0);
        enq    = validF && readyF && !flushD;
        deq    = validD && !stallD && !flushD;
    end

    // Next-state for pointers and occupancy; a flush discards everything,
    // including a fetch presented in the same cycle.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flushD) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) wptr_d = wptr_q + PTR_W'(1);
            if (deq) rptr_d = rptr_q + PTR_W'(1);
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage write at the tail on every accepted fetch.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem_q[wptr_q] <= InstrF;
            pc_mem_q[wptr_q]    <= PCF;
        end
    end

    // Decode-side view of the head entry; an empty buffer shows a NOP at PC 0.
    always_comb begin
        InstrD   = validD ? instr_mem_q[rptr_q] : NOP_INSTR;
        PCD      = validD ? pc_mem_q[rptr_q]    : 32'd0;
        PCPlus4D = PCD + 32'd4;
    end

    assign count = count_q;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] bubble_cycles_q, bubble_cycles_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Counter next-state: decode stalled on a real entry, or decode starved.
    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        bubble_cycles_d = bubble_cycles_q;
        if (validD && stallD && !flushD) stall_cycles_d = sat_inc(stall_cycles_q);
        if (!validD)                     bubble_cycles_d = sat_inc(bubble_cycles_q);
    end

    // Saturating performance counters, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q  <= '0;
            bubble_cycles_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            bubble_cycles_q <= bubble_cycles_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer: directed scenarios plus randomized traffic
// against a queue-based reference model of the fetch/decode FIFO.
module tb_if_id_buffer;

    localparam int          DEPTH = 2;
    localparam int          CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam int          VW    = 1 + 32 + 32 + 32 + 1 + CNT_W;

    logic              clk;
    logic              rst;
    logic [31:0]       PCF;
    logic [31:0]       InstrF;
    logic              validF;
    logic              readyF;
    logic              stallD;
    logic              flushD;
    logic [31:0]       InstrD;
    logic [31:0]       PCD;
    logic [31:0]       PCPlus4D;
    logic              validD;
    logic [CNT_W-1:0]  count;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       bubble_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk      (clk),
        .rst      (rst),
        .PCF      (PCF),
        .InstrF   (InstrF),
        .validF   (validF),
        .readyF   (readyF),
        .stallD   (stallD),
        .flushD   (flushD),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .validD   (validD),
        .count    (count)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t mq[$];
    int unsigned m_stall  = 0;
    int unsigned m_bubble = 0;

    function automatic void model_clear();
        mq.delete();
        m_stall  = 0;
        m_bubble = 0;
    endfunction

    // Applies one rising edge using the inputs present before the edge.
    function automatic void model_update();
        bit   rdy;
        bit   vd;
        bit   en;
        bit   de;
        ent_t e;
        rdy = (mq.size() < DEPTH);
        vd  = (mq.size() != 0);
        en  = validF && rdy && !flushD;
        de  = vd && !stallD && !flushD;
        if (vd && stallD && !flushD) m_stall++;
        if (!vd) m_bubble++;
        if (flushD) begin
            mq.delete();
        end else begin
            if (de) void'(mq.pop_front());
            if (en) begin
                e.pc    = PCF;
                e.instr = InstrF;
                mq.push_back(e);
            end
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [31:0] pc;
        logic [31:0] ins;
        logic        v;
        v   = (mq.size() != 0);
        pc  = v ? mq[0].pc : 32'd0;
        ins = v ? mq[0].instr : NOP;
        return {v, ins, pc, pc + 32'd4, (mq.size() < DEPTH), CNT_W'(mq.size())};
    endfunction

    function automatic bit model_ready();
        return (mq.size() < DEPTH);
    endfunction

    logic [VW-1:0] obs_vec;
    assign obs_vec = {validD, InstrD, PCD, PCPlus4D, readyF, count};

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit st, input bit fl);
        validF = v;
        PCF    = pc;
        InstrF = ins;
        stallD = st;
        flushD = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_update();
        else     model_clear();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs_vec !== {1'b0, NOP, 32'd0, 32'd4, 1'b1, CNT_W'(0)}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs_vec,
                     {1'b0, NOP, 32'd0, 32'd4, 1'b1, CNT_W'(0)});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] ins [3];
        ins[0] = 32'hAAAA_0001;
        ins[1] = 32'hBBBB_0002;
        ins[2] = 32'hCCCC_0003;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), ins[i], 1'b0, 1'b0);
            tick();
            checks++;
            if (InstrD !== ins[i] || PCD !== 32'(i * 4) || count !== CNT_W'(1) || readyF !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d instr=%h pc=%h cnt=%0d rdy=%b want instr=%h pc=%h cnt=1 rdy=1",
                         i, InstrD, PCD, count, readyF, ins[i], i * 4);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs_vec !== exp_vec() || validD !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain got=%h want=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_fill();
        drive(1'b1, 32'h10, 32'h0000_1010, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h14, 32'h0000_1414, 1'b1, 1'b0);
        tick();
        checks++;
        if (count !== CNT_W'(2) || readyF !== 1'b0 || PCD !== 32'h10) begin
            failures++;
            $display("FAIL fill_full cnt=%0d rdy=%b pc=%h want cnt=2 rdy=0 pc=10", count, readyF, PCD);
        end
        drive(1'b1, 32'h18, 32'h0000_1818, 1'b1, 1'b0);
        tick();
        checks++;
        if (count !== CNT_W'(2) || readyF !== 1'b0 || PCD !== 32'h10 || obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL fill_hold cnt=%0d rdy=%b pc=%h want cnt=2 rdy=0 pc=10", count, readyF, PCD);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (PCD !== 32'h14 || InstrD !== 32'h0000_1414 || readyF !== 1'b1 || count !== CNT_W'(1)) begin
            failures++;
            $display("FAIL fill_release pc=%h instr=%h rdy=%b cnt=%0d want pc=14 rdy=1 cnt=1",
                     PCD, InstrD, readyF, count);
        end
        tick();
        checks++;
        if (validD !== 1'b0 || obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL fill_empty got=%h want=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h20, 32'h0000_2020, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h24, 32'h0000_2424, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1);
        tick();
        checks++;
        if (count !== CNT_W'(0) || validD !== 1'b0 || InstrD !== NOP || PCD !== 32'd0) begin
            failures++;
            $display("FAIL flush_clear cnt=%0d vld=%b instr=%h pc=%h want cnt=0 vld=0 instr=0 pc=0",
                     count, validD, InstrD, PCD);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (validD !== 1'b0 || PCD === 32'h100) begin
            failures++;
            $display("FAIL flush_drop vld=%b pc=%h want vld=0 pc!=100", validD, PCD);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pc;
        int          accepted;
        int          cyc;
        logic [31:0] seen[$];
        bit          acc;
        bit          st;
        pc       = 32'h200;
        accepted = 0;
        cyc      = 0;
        while ((accepted < 10 || mq.size() != 0) && cyc < 80) begin
            st = cyc[0];
            drive(accepted < 10, pc, ~pc, st, 1'b0);
            acc = (accepted < 10) && model_ready();
            if (validD && !st) seen.push_back(PCD);
            tick();
            if (acc) begin
                pc = pc + 32'd4;
                accepted++;
            end
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL wrap_cycle_%0d got=%h want=%h", cyc, obs_vec, exp_vec());
            end
            cyc++;
        end
        checks++;
        if (seen.size() != 10 || cyc >= 80) begin
            failures++;
            $display("FAIL wrap_count got=%0d want=10 cycles=%0d", seen.size(), cyc);
        end
        for (int i = 0; i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== 32'h200 + 32'(i * 4)) begin
                failures++;
                $display("FAIL wrap_order_%0d got=%h want=%h", i, seen[i], 32'h200 + 32'(i * 4));
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_pc_wrap();
        drive(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b0);
        tick();
        checks++;
        if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0000_0000) begin
            failures++;
            $display("FAIL pc_wrap pc=%h pc4=%h want pc=fffffffc pc4=0", PCD, PCPlus4D);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h300, 32'h0000_3030, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h304, 32'h0000_3434, 1'b1, 1'b0);
        tick();
        checks++;
        if (count !== CNT_W'(2)) begin
            failures++;
            $display("FAIL async_pre cnt=%0d want=2", count);
        end
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (count !== CNT_W'(0) || validD !== 1'b0 || readyF !== 1'b1 || InstrD !== NOP) begin
            failures++;
            $display("FAIL async_reset cnt=%0d vld=%b rdy=%b instr=%h want cnt=0 vld=0 rdy=1 instr=0",
                     count, validD, readyF, InstrD);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) == 0, ($urandom % 16) == 0);
            tick();
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random_%0d got=%h want=%h", i, obs_vec, exp_vec());
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

`ifdef IF_ID_PERF_CNT_EN
    task automatic test_perf();
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        drive(1'b1, 32'h40, 32'h0000_4040, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_cycles !== 32'd5 || stall_cycles !== 32'(m_stall)) begin
            failures++;
            $display("FAIL perf_stall got=%0d want=5", stall_cycles);
        end
        checks++;
        if (bubble_cycles < 32'd3 || bubble_cycles !== 32'(m_bubble)) begin
            failures++;
            $display("FAIL perf_bubble got=%0d want=%0d", bubble_cycles, m_bubble);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_fill();
        test_flush();
        test_wrap();
        test_pc_wrap();
        test_async_reset();
        test_random();
`ifdef IF_ID_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
